// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES types and S-box constant tables (forward/inverse).
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sb_fsm_t;

    // One row of 16 table entries per literal; entry 0 sits in the top byte.
    localparam logic [2047:0] C_SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] C_SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Entry x occupies bits [8*(255-x)+7 -: 8], i.e. MSB index {~x, 3'b111}.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return C_SBOX_FWD[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return C_SBOX_INV[{~x, 3'b111} -: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational single-byte AES S-box; the inverse table and
//               i_inv select exist only when AES_INV_SBOX_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
`ifdef AES_INV_SBOX_EN
    input  logic       i_inv,
`endif
    output logic [7:0] o_byte
);

`ifdef AES_INV_SBOX_EN
    assign o_byte = i_inv ? sbox_inv(i_byte) : sbox_fwd(i_byte);
`else
    assign o_byte = sbox_fwd(i_byte);
`endif

endmodule
`default_nettype wire

// File: rtl/sub_bytes_serial.sv
`default_nettype none
// ============================================================================
// Module      : sub_bytes_serial
// Description : AES SubBytes over a 128-bit state, LANES bytes per cycle,
//               valid/ready in and out. Optional macro AES_INV_SBOX_EN adds
//               port in_inv selecting the inverse S-box per block.
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bytes_serial
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
`ifdef AES_INV_SBOX_EN
    input  logic         in_inv,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_bus,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_bus
);

    localparam int C_NCHUNK  = 16 / LANES;
    localparam int C_CNT_W   = (C_NCHUNK > 1) ? $clog2(C_NCHUNK) : 1;
    localparam int C_LANE_W  = LANES * 8;
    localparam int C_BASE_SH = $clog2(C_LANE_W);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_NCHUNK - 1);

    sb_fsm_t              fsm_q,   fsm_d;
    aes_state_t           state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q,   cnt_d;
`ifdef AES_INV_SBOX_EN
    logic                 inv_q,   inv_d;
`endif

    logic [6:0]           w_base;
    logic [C_LANE_W-1:0]  w_chunk;
    logic [C_LANE_W-1:0]  w_sub;

    // With LANES=16 the counter is stuck at 0, so truncating the shifted
    // value to 7 bits never drops a set bit.
    assign w_base  = 7'({cnt_q, {C_BASE_SH{1'b0}}});
    assign w_chunk = state_q[w_base +: C_LANE_W];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox u_sbox (
            .i_byte (w_chunk[8*i +: 8]),
`ifdef AES_INV_SBOX_EN
            .i_inv  (inv_q),
`endif
            .o_byte (w_sub[8*i +: 8])
        );
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
`ifdef AES_INV_SBOX_EN
        inv_d     = inv_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            BUSY: begin
                state_d[w_base +: C_LANE_W] = w_sub;
                if (cnt_q == C_CNT_LAST) begin
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase

        // Shared by IDLE and DONE so a new block can enter on the same edge
        // that retires the previous result.
        if (in_ready && in_valid) begin
            state_d = in_bus;
            cnt_d   = '0;
`ifdef AES_INV_SBOX_EN
            inv_d   = in_inv;
`endif
            fsm_d   = BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            cnt_q   <= '0;
`ifdef AES_INV_SBOX_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef AES_INV_SBOX_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign out_bus = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_bytes_serial
// Description : Self-checking bench for sub_bytes_serial at LANES = 4, 8, 16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_serial;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid_s  [NDUT];
    logic         out_ready_s [NDUT];
    logic [127:0] in_bus_s    [NDUT];
    logic         in_ready_w  [NDUT];
    logic         out_valid_w [NDUT];
    logic [127:0] out_bus_w   [NDUT];
`ifdef AES_INV_SBOX_EN
    logic         in_inv_s    [NDUT];
`endif

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sub_bytes_serial #(.LANES(4 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
`ifdef AES_INV_SBOX_EN
            .in_inv    (in_inv_s[g]),
`endif
            .in_valid  (in_valid_s[g]),
            .in_ready  (in_ready_w[g]),
            .in_bus    (in_bus_s[g]),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready_s[g]),
            .out_bus   (out_bus_w[g])
        );
    end

    int checks = 0;
    int errors = 0;

    // Reference S-box derived from GF(2^8) inversion plus the affine map.
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] b, int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] xi;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            xi = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) xi = 8'(y);
            s = xi ^ rotl8(xi, 1) ^ rotl8(xi, 2) ^ rotl8(xi, 3) ^ rotl8(xi, 4) ^ 8'h63;
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] sub_model(logic [127:0] st, logic inv);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = inv ? inv_tab[st[8*k +: 8]] : fwd_tab[st[8*k +: 8]];
        return r;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_done(int d, string nm);
        int cyc = 0;
        while (!out_valid_w[d] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, 128'(cyc), 128'(16 / (4 << d)));
    endtask

    task automatic accept_and_wait(int d, logic [127:0] din, logic inv, string nm);
        @(negedge clk);
        chk({nm, "_in_ready"}, 128'(in_ready_w[d]), 128'(1));
        in_valid_s[d] = 1'b1;
        in_bus_s[d]   = din;
`ifdef AES_INV_SBOX_EN
        in_inv_s[d]   = inv;
`endif
        @(negedge clk);
        in_valid_s[d] = 1'b0;
        in_bus_s[d]   = ~din;
        if (inv) in_bus_s[d] = din ^ 128'h1;
        wait_done(d, nm);
    endtask

    task automatic release_out(int d, string nm);
        out_ready_s[d] = 1'b1;
        @(negedge clk);
        out_ready_s[d] = 1'b0;
        chk({nm, "_out_valid_clr"}, 128'(out_valid_w[d]), 128'(0));
        chk({nm, "_idle_ready"},    128'(in_ready_w[d]),  128'(1));
    endtask

    task automatic run_block(int d, logic [127:0] din, logic inv, logic [127:0] exp, string nm);
        accept_and_wait(d, din, inv, nm);
        chk({nm, "_out_bus"}, out_bus_w[d], exp);
        release_out(d, nm);
    endtask

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic [127:0] dout;
        string        name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] a, b, exp_a;
        logic         inv, seen;

        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            in_valid_s[d]  = 1'b0;
            out_ready_s[d] = 1'b0;
            in_bus_s[d]    = '0;
`ifdef AES_INV_SBOX_EN
            in_inv_s[d]    = 1'b0;
`endif
        end
        build_tables();

        vecs.push_back('{128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19, 1'b0,
                         128'h3052411e_e55db4b8_f198bfe0_ae1127d4, "fips"});
        vecs.push_back('{{16{8'h00}}, 1'b0, {16{8'h63}}, "all00"});
        vecs.push_back('{{16{8'h53}}, 1'b0, {16{8'hed}}, "all53"});
        vecs.push_back('{128'h0f0e0d0c_0b0a0908_07060504_03020100, 1'b0,
                         128'h76abd7fe_2b670130_c56f6bf2_7b777c63, "incr"});
`ifdef AES_INV_SBOX_EN
        vecs.push_back('{{16{8'h63}}, 1'b1, {16{8'h00}}, "inv63"});
        vecs.push_back('{{16{8'hed}}, 1'b1, {16{8'h53}}, "invED"});
`endif

        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("reset_in_ready_%0d", d),  128'(in_ready_w[d]),  128'(1));
            chk($sformatf("reset_out_valid_%0d", d), 128'(out_valid_w[d]), 128'(0));
            chk($sformatf("reset_out_bus_%0d", d),   out_bus_w[d],         128'(0));
        end
        rst = 1'b0;

        for (int d = 0; d < NDUT; d++)
            for (int v = 0; v < vecs.size(); v++)
                run_block(d, vecs[v].din, vecs[v].inv, vecs[v].dout,
                          $sformatf("%s_l%0d", vecs[v].name, 4 << d));

        for (int d = 0; d < NDUT; d++)
            for (int n = 0; n < 12; n++) begin
                a = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_INV_SBOX_EN
                inv = 1'($urandom_range(0, 1));
`else
                inv = 1'b0;
`endif
                run_block(d, a, inv, sub_model(a, inv), $sformatf("rand_l%0d_%0d", 4 << d, n));
            end

        // Consumer stall: result and handshake lines must hold, in_valid ignored.
        a = {$urandom, $urandom, $urandom, $urandom};
        exp_a = sub_model(a, 1'b0);
        accept_and_wait(0, a, 1'b0, "stall");
        for (int i = 0; i < 10; i++) begin
            in_valid_s[0] = i[0];
            in_bus_s[0]   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk($sformatf("stall_out_valid_%0d", i), 128'(out_valid_w[0]), 128'(1));
            chk($sformatf("stall_out_bus_%0d", i),   out_bus_w[0],         exp_a);
            chk($sformatf("stall_in_ready_%0d", i),  128'(in_ready_w[0]),  128'(0));
        end
        in_valid_s[0] = 1'b0;
        release_out(0, "stall");

        // Back-to-back: second block enters on the first output handshake edge.
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        accept_and_wait(0, a, 1'b0, "b2b_a");
        chk("b2b_a_out_bus", out_bus_w[0], sub_model(a, 1'b0));
        out_ready_s[0] = 1'b1;
        in_valid_s[0]  = 1'b1;
        in_bus_s[0]    = b;
        #1;
        chk("b2b_in_ready_follows_out_ready", 128'(in_ready_w[0]), 128'(1));
        @(negedge clk);
        out_ready_s[0] = 1'b0;
        in_valid_s[0]  = 1'b0;
        chk("b2b_busy_out_valid", 128'(out_valid_w[0]), 128'(0));
        chk("b2b_busy_in_ready",  128'(in_ready_w[0]),  128'(0));
        wait_done(0, "b2b_b");
        chk("b2b_b_out_bus", out_bus_w[0], sub_model(b, 1'b0));
        release_out(0, "b2b_b");

        // Reset in the second BUSY cycle aborts the block without output.
        a = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        in_valid_s[0] = 1'b1;
        in_bus_s[0]   = a;
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        out_ready_s[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready_s[0] = 1'b0;
        chk("abort_in_ready",  128'(in_ready_w[0]),  128'(1));
        chk("abort_out_valid", 128'(out_valid_w[0]), 128'(0));
        chk("abort_out_bus",   out_bus_w[0],         128'(0));
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid_w[0]) seen = 1'b1;
        end
        chk("abort_no_output", 128'(seen), 128'(0));
        run_block(0, a, 1'b0, sub_model(a, 1'b0), "post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
